fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register of the MIPS core; directly upstream of the main control decoder.
- Owns the PC and issues requests to instruction memory, which may insert wait states.
- Delivers the registered instruction and its opcode to the decode/control stage.
- Handles hazard-unit stalls, ID-stage jump redirects and EX-stage branch redirects, with bubble insertion.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/if_id_reg.sv | 32 +++
 rtl/fetch_stage.sv | 148 ++++++++++++++
 tb/tb_fetch_stage.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcodes, the canonical NOP encoding and the fetch FSM states.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // sll $0,$0,0 -- the architectural NOP used for bubbles
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

  // J-type target: upper PC nibble of the delay-free successor plus the 26-bit word index
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [31:0] instr);
    return {pc_plus4[31:28], instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority: reset > bubble > load > hold.
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        bubble,
  input  logic        load,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc_plus4,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4
);

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid    <= 1'b0;
      instr    <= NOP_INSTR;
      pc_plus4 <= 32'h0;
    end else if (bubble) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end else if (load) begin
      valid    <= 1'b1;
      instr    <= load_instr;
      pc_plus4 <= load_pc_plus4;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem request, stall/redirect handling and the IF/ID register.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 imem_req,
  output logic [31:0]          imem_addr,
  input  logic [31:0]          imem_rdata,
  input  logic                 imem_ready,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_target,
  input  logic                 jump,
  output logic                 if_id_valid,
  output logic [31:0]          if_id_instr,
  output logic [31:0]          if_id_pc_plus4,
  output logic [5:0]           id_opcode,
  output logic [CNT_WIDTH-1:0] fetch_count
);

  fetch_state_t state, state_next;

  logic [31:0]          pc, pc_next;
  logic [31:0]          pc_plus4;
  logic [31:0]          hold_instr, hold_pc_plus4;
  logic                 hold_valid;

  logic                 redirect;
  logic [31:0]          redirect_pc;

  logic                 ifid_load, ifid_bubble;
  logic [31:0]          ifid_load_instr, ifid_load_pc_plus4;
  logic                 hold_capture, hold_release;
  logic                 count_inc;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  assign imem_req  = !reset && (state == FETCH);
  assign id_opcode = if_id_instr[31:26];

  // A jump is only real when IF/ID actually holds the J instruction.
  assign redirect    = branch_taken || (jump && if_id_valid);
  assign redirect_pc = (branch_taken ? branch_target
                                     : jump_target(if_id_pc_plus4, if_id_instr)) & ~32'h3;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    // NOTE: assigning a default first keeps every path covered so no latch is inferred.
    state_next = state;
    if (redirect) begin
      state_next = FETCH;
    end else begin
      unique case (state)
        FETCH: if (imem_ready && stall)   state_next = HOLD;
        HOLD:  if (!stall && hold_valid)  state_next = FETCH;
        default:                          state_next = FETCH;
      endcase
    end
  end

  // Output / datapath control logic
  always_comb begin
    pc_next            = pc;
    ifid_load          = 1'b0;
    ifid_bubble        = 1'b0;
    ifid_load_instr    = imem_rdata;
    ifid_load_pc_plus4 = pc_plus4;
    hold_capture       = 1'b0;
    hold_release       = 1'b0;
    count_inc          = 1'b0;

    if (redirect) begin
      // Redirect wins over stall and discards whatever memory returned this cycle.
      pc_next     = redirect_pc;
      ifid_bubble = 1'b1;
    end else begin
      unique case (state)
        FETCH: begin
          if (imem_ready) begin
            pc_next = pc_plus4;
            if (stall) begin
              hold_capture = 1'b1;
            end else begin
              ifid_load = 1'b1;
              count_inc = 1'b1;
            end
          end else if (!stall) begin
            ifid_bubble = 1'b1;
          end
        end
        HOLD: begin
          if (!stall && hold_valid) begin
            ifid_load          = 1'b1;
            ifid_load_instr    = hold_instr;
            ifid_load_pc_plus4 = hold_pc_plus4;
            hold_release       = 1'b1;
            count_inc          = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // PC, hold buffer and performance counter
  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= RESET_PC;
      hold_instr    <= NOP_INSTR;
      hold_pc_plus4 <= 32'h0;
      hold_valid    <= 1'b0;
      fetch_count   <= '0;
    end else begin
      pc <= pc_next;
      if (hold_capture) begin
        hold_instr    <= imem_rdata;
        hold_pc_plus4 <= pc_plus4;
        hold_valid    <= 1'b1;
      end else if (redirect || hold_release) begin
        hold_valid <= 1'b0;
      end
      if (count_inc) fetch_count <= fetch_count + CNT_WIDTH'(1);
    end
  end

  if_id_reg u_if_id_reg (
    .clk           (clk),
    .reset         (reset),
    .bubble        (ifid_bubble),
    .load          (ifid_load),
    .load_instr    (ifid_load_instr),
    .load_pc_plus4 (ifid_load_pc_plus4),
    .valid         (if_id_valid),
    .instr         (if_id_instr),
    .pc_plus4      (if_id_pc_plus4)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: sequential fetch, wait states, stall/HOLD, jump, branch, wrap, reset.
module tb_fetch_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic [5:0]  id_opcode;
  logic [31:0] fetch_count;

  int passed = 0;
  int total  = 0;

  fetch_stage #(.RESET_PC(32'h0), .CNT_WIDTH(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_ready     (imem_ready),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .jump           (jump),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .id_opcode      (id_opcode),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one rising edge, then settle 1 time unit past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic v, input logic [31:0] ins,
                            input logic [31:0] p4);
    check({tag, ".valid"}, 32'(if_id_valid), 32'(v));
    check({tag, ".instr"}, if_id_instr, ins);
    check({tag, ".pc4"},   if_id_pc_plus4, p4);
  endtask

  initial begin
    reset = 1'b1; imem_rdata = 32'h0; imem_ready = 1'b0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0; jump = 1'b0;
    tick(); tick();

    // Reset state
    check("rst.req",   32'(imem_req), 32'h0);
    check("rst.addr",  imem_addr, 32'h0);
    check("rst.count", fetch_count, 32'h0);
    check_ifid("rst", 1'b0, 32'h0, 32'h0);

    // Sequential fetch 0,4,8
    reset = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h8C08_0004;
    #1;
    check("seq0.req",  32'(imem_req), 32'h1);
    check("seq0.addr", imem_addr, 32'h0);
    tick();
    check("seq1.addr",  imem_addr, 32'h4);
    check_ifid("seq1", 1'b1, 32'h8C08_0004, 32'h4);
    check("seq1.op",    32'(id_opcode), 32'(OP_LW));
    check("seq1.count", fetch_count, 32'd1);
    imem_rdata = 32'h2009_0005;
    tick();
    check("seq2.addr",  imem_addr, 32'h8);
    check_ifid("seq2", 1'b1, 32'h2009_0005, 32'h8);
    check("seq2.op",    32'(id_opcode), 32'(OP_ADDI));

    // Three wait states at pc=8
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wait.addr",  imem_addr, 32'h8);
      check("wait.valid", 32'(if_id_valid), 32'h0);
      check("wait.count", fetch_count, 32'd2);
    end
    imem_ready = 1'b1; imem_rdata = 32'h0000_0020;
    tick();
    check("wready.addr", imem_addr, 32'hC);
    check_ifid("wready", 1'b1, 32'h0000_0020, 32'hC);
    check("wready.op",   32'(id_opcode), 32'(OP_RTYPE));
    check("wready.count", fetch_count, 32'd3);

    // Stall during an accepted fetch at pc=12 -> HOLD for two cycles
    imem_rdata = 32'hAC0A_0008; stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("hold.req",  32'(imem_req), 32'h0);
      check("hold.addr", imem_addr, 32'h10);
      check_ifid("hold", 1'b1, 32'h0000_0020, 32'hC);
      check("hold.count", fetch_count, 32'd3);
    end
    stall = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    tick();
    check_ifid("release", 1'b1, 32'hAC0A_0008, 32'h10);
    check("release.op",    32'(id_opcode), 32'(OP_SW));
    check("release.count", fetch_count, 32'd4);
    check("release.req",   32'(imem_req), 32'h1);
    check("release.addr",  imem_addr, 32'h10);

    // Fetch a J at pc=0x10, then resolve it
    imem_rdata = 32'h0800_0010;
    tick();
    check_ifid("jfetch", 1'b1, 32'h0800_0010, 32'h14);
    check("jfetch.op", 32'(id_opcode), 32'(OP_J));
    jump = 1'b1; imem_rdata = 32'h1111_1111;
    tick();
    check("jump.addr",  imem_addr, 32'h40);
    check_ifid("jump", 1'b0, 32'h0, 32'h14);
    check("jump.count", fetch_count, 32'd5);

    // Jump with an empty IF/ID is ignored
    imem_ready = 1'b0;
    tick();
    check("jign.addr",  imem_addr, 32'h40);
    check("jign.valid", 32'(if_id_valid), 32'h0);
    jump = 1'b0;

    // Enter HOLD at pc=0x40, then branch+jump+stall together
    imem_ready = 1'b1; imem_rdata = 32'h8C0B_0000; stall = 1'b1;
    tick();
    check("bhold.req",  32'(imem_req), 32'h0);
    check("bhold.addr", imem_addr, 32'h44);
    branch_taken = 1'b1; branch_target = 32'h103; jump = 1'b1;
    tick();
    check("br.addr",  imem_addr, 32'h100);
    check("br.req",   32'(imem_req), 32'h1);
    check("br.valid", 32'(if_id_valid), 32'h0);
    check("br.instr", if_id_instr, 32'h0);
    branch_taken = 1'b0; jump = 1'b0; stall = 1'b0; imem_ready = 1'b0;
    tick();
    check("brpost.valid", 32'(if_id_valid), 32'h0);
    check("brpost.addr",  imem_addr, 32'h100);
    check("brpost.count", fetch_count, 32'd5);

    // PC wrap at 0xFFFF_FFFC
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
    tick();
    check("wrap0.addr", imem_addr, 32'hFFFF_FFFC);
    branch_taken = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h1000_0003;
    tick();
    check("wrap1.addr", imem_addr, 32'h0);
    check_ifid("wrap1", 1'b1, 32'h1000_0003, 32'h0);
    check("wrap1.op",    32'(id_opcode), 32'(OP_BEQ));
    check("wrap1.count", fetch_count, 32'd6);

    // Reset asserted while in HOLD
    stall = 1'b1; imem_rdata = 32'h2222_2222;
    tick();
    check("rhold.req", 32'(imem_req), 32'h0);
    reset = 1'b1;
    tick();
    check("rhold.addr",  imem_addr, 32'h0);
    check("rhold.valid", 32'(if_id_valid), 32'h0);
    check("rhold.req",   32'(imem_req), 32'h0);
    check("rhold.count", fetch_count, 32'h0);
    reset = 1'b0; stall = 1'b0;
    #1;
    check("rrel.req", 32'(imem_req), 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
